// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: widths, opcodes,
// requester IDs, the in-flight tag format and the round-robin pick.
package alu_arb_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  // Opcode encoding shared with the ALU; the arbiter only passes it through.
  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W-1:0] OP_SHR = 3'b111;

  // Requester identifiers, also used as the value of the priority pointer.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One in-flight operation marker: the id is meaningful only when valid is set.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  // Round-robin choice between two requesters. On a tie the requester that
  // was not granted last wins; a lone requester always wins.
  function automatic tag_t pick_grant(input logic v0, input logic v1,
                                      input logic last);
    tag_t g;
    g.valid = v0 | v1;
    if (v0 && v1) begin
      g.id = ~last;
    end else if (v1) begin
      g.id = REQ1;
    end else begin
      g.id = REQ0;
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_tag_delay.sv
// Fixed-depth shift register carrying {valid, id} for every cycle's issue
// slot, so the tag at the output lines up with the ALU result it describes.
module alu_tag_delay
  import alu_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_i,
  output tag_t tag_o,
  output logic any_valid_o
);

  tag_t stage_q [DEPTH];
  logic any_valid;

  // Shift one stage per cycle; only the valid bits are cleared by reset.
  always_ff @(posedge clk) begin
    // NOTE: registers are written with non-blocking assignments so every stage
    // samples its neighbour's old value; blocking here would collapse the chain.
    if (reset) begin
      // NOTE: the id bits are left unreset on purpose; they are ignored while
      // valid is low, so clearing them would only add reset fan-out.
      stage_q[0].valid <= 1'b0;
    end else begin
      stage_q[0] <= tag_i;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (reset) begin
        stage_q[i].valid <= 1'b0;
      end else begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // OR of all valid bits: anything still travelling towards the ALU output.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stage_q[i].valid;
    end
  end

  assign tag_o       = stage_q[DEPTH-1];
  assign any_valid_o = any_valid;

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin front end sharing one pipelined ALU between two requesters.
// Grants are combinational, the granted operation is registered into the
// ALU, and a tag delay line steers each result back to the requester that
// issued it after a fixed latency.
module alu_req_arbiter
  import alu_arb_pkg::*;
#(
  parameter int ALU_LATENCY = 2  // legal range 1..8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [OP_W-1:0]   alu_op_code,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy
);

  // Tag line is one stage longer than the ALU so its output coincides with
  // alu_result for the operation it tags (the ALU input register adds one).
  localparam int TAG_DEPTH = ALU_LATENCY + 1;

  tag_t              gnt;
  logic              last_gnt_q, last_gnt_d;
  logic [OP_W-1:0]   alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d;
  logic [DATA_W-1:0] alu_b_q, alu_b_d;
  tag_t              tag_in, tag_out;
  logic              tags_busy;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_W-1:0] rsp1_data_q, rsp1_data_d;

  // Combinational grant: at most one ready, none while reset is high.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    gnt        = '{valid: 1'b0, id: REQ0};
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!reset) begin
      gnt        = pick_grant(req0_valid, req1_valid, last_gnt_q);
      req0_ready = gnt.valid && (gnt.id == REQ0);
      req1_ready = gnt.valid && (gnt.id == REQ1);
    end
  end

  // Next issue slot: the granted operation, or an idle ADD 0,0 bubble.
  always_comb begin
    last_gnt_d = last_gnt_q;
    alu_op_d   = OP_ADD;
    alu_a_d    = '0;
    alu_b_d    = '0;
    tag_in     = gnt;
    if (gnt.valid) begin
      last_gnt_d = gnt.id;
      if (gnt.id == REQ0) begin
        alu_op_d = req0_op;
        alu_a_d  = req0_a;
        alu_b_d  = req0_b;
      end else begin
        alu_op_d = req1_op;
        alu_a_d  = req1_a;
        alu_b_d  = req1_b;
      end
    end
  end

  // Priority pointer and registered ALU drive.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= REQ1;
      alu_op_q   <= OP_ADD;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
    end
  end

  alu_tag_delay #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_delay (
    .clk         (clk),
    .reset       (reset),
    .tag_i       (tag_in),
    .tag_o       (tag_out),
    .any_valid_o (tags_busy)
  );

  // Steer the ALU result to the tagged requester; the other port holds.
  always_comb begin
    rsp0_valid_d = tag_out.valid && (tag_out.id == REQ0);
    rsp1_valid_d = tag_out.valid && (tag_out.id == REQ1);
    rsp0_data_d  = rsp0_valid_d ? alu_result : rsp0_data_q;
    rsp1_data_d  = rsp1_valid_d ? alu_result : rsp1_data_q;
  end

  // Response registers: one-cycle valid pulse, data held between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign alu_op_code = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_data   = rsp0_data_q;
  assign rsp1_data   = rsp1_data_q;
  assign busy        = tags_busy | rsp0_valid_q | rsp1_valid_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: a small pipelined ALU model feeds
// alu_result, and a transaction-level model (pending ops, expected response
// schedule keyed by cycle number) predicts every output each cycle.
module tb_alu_req_arbiter;
  import alu_arb_pkg::*;

  localparam int L = 2;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  typedef struct {
    int         due;
    bit         id;
    logic [7:0] res;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic [2:0] req0_op = '0, req1_op = '0;
  logic [7:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic       req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [7:0] rsp0_data, rsp1_data, alu_a, alu_b, alu_result;
  logic [2:0] alu_op_code;

  always #5 clk = ~clk;

  alu_req_arbiter #(.ALU_LATENCY(L)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .alu_op_code(alu_op_code), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .busy(busy)
  );

  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    alu_fn = 'x;
    case (op)
      OP_ADD: alu_fn = a + b;
      OP_SUB: alu_fn = a - b;
      OP_AND: alu_fn = a & b;
      OP_OR:  alu_fn = a | b;
      OP_XOR: alu_fn = a ^ b;
      OP_NOT: alu_fn = ~a;
      OP_SHL: alu_fn = a << 1;
      OP_SHR: alu_fn = a >> 1;
      default: alu_fn = 'x;
    endcase
  endfunction

  // External ALU: result valid L edges after its inputs are driven.
  logic [7:0] alu_pipe [L];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_fn(alu_op_code, alu_a, alu_b);
    for (int k = 1; k < L; k++) alu_pipe[k] <= alu_pipe[k-1];
  end
  assign alu_result = alu_pipe[L-1];

  // Requester side and reference model state.
  op_t        q0[$], q1[$];
  op_t        pend [2];
  bit         pend_v [2] = '{0, 0};
  bit         gap_en = 0;
  exp_t       sched[$];
  bit         m_last = 1'b1;
  logic [7:0] m_rsp [2] = '{8'h00, 8'h00};
  op_t        m_alu = '0;
  int         cyc = 0;
  int         grant_log[$];
  int         pulses [2] = '{0, 0};
  int         n_vec = 0, n_err = 0;

  // One clock cycle: drive at negedge, check readies, model the edge, check outputs.
  task automatic cycle(input bit rst);
    bit [1:0]   er;
    bit         ev [2];
    bit         eb;
    bit         gid;
    @(negedge clk);
    reset = rst;
    if (!pend_v[0] && q0.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
      pend[0] = q0.pop_front(); pend_v[0] = 1;
    end
    if (!pend_v[1] && q1.size() > 0 && (!gap_en || $urandom_range(0, 2) != 0)) begin
      pend[1] = q1.pop_front(); pend_v[1] = 1;
    end
    req0_valid = pend_v[0]; req0_op = pend[0].op; req0_a = pend[0].a; req0_b = pend[0].b;
    req1_valid = pend_v[1]; req1_op = pend[1].op; req1_a = pend[1].a; req1_b = pend[1].b;
    #1;
    er = 2'b00;
    if (!rst) begin
      if (pend_v[0] && pend_v[1]) er[m_last ? 0 : 1] = 1'b1;
      else if (pend_v[0]) er[0] = 1'b1;
      else if (pend_v[1]) er[1] = 1'b1;
    end
    n_vec += 2;
    if (req0_ready !== er[0]) begin
      n_err++; $display("FAIL ready0 cyc=%0d: got %b want %b", cyc, req0_ready, er[0]);
    end
    if (req1_ready !== er[1]) begin
      n_err++; $display("FAIL ready1 cyc=%0d: got %b want %b", cyc, req1_ready, er[1]);
    end
    if (req0_ready === 1'b1) grant_log.push_back(0);
    else if (req1_ready === 1'b1) grant_log.push_back(1);

    @(posedge clk);
    cyc++;
    #1;
    if (rst) begin
      sched.delete(); m_last = 1'b1; m_alu = '0; m_rsp = '{8'h00, 8'h00};
    end else if (er != 2'b00) begin
      gid = er[1];
      sched.push_back('{due: cyc + L + 1, id: gid,
                        res: alu_fn(pend[gid].op, pend[gid].a, pend[gid].b)});
      m_last = gid; m_alu = pend[gid]; pend_v[gid] = 0;
    end else begin
      m_alu = '0;
    end
    ev = '{0, 0};
    while (sched.size() > 0 && sched[0].due < cyc) void'(sched.pop_front());
    if (sched.size() > 0 && sched[0].due == cyc) begin
      ev[sched[0].id] = 1; m_rsp[sched[0].id] = sched[0].res;
    end
    eb = sched.size() > 0;
    if (rsp0_valid === 1'b1) pulses[0]++;
    if (rsp1_valid === 1'b1) pulses[1]++;
    n_vec += 8;
    if (alu_op_code !== m_alu.op) begin
      n_err++; $display("FAIL alu_op cyc=%0d: got %h want %h", cyc, alu_op_code, m_alu.op);
    end
    if (alu_a !== m_alu.a) begin
      n_err++; $display("FAIL alu_a cyc=%0d: got %h want %h", cyc, alu_a, m_alu.a);
    end
    if (alu_b !== m_alu.b) begin
      n_err++; $display("FAIL alu_b cyc=%0d: got %h want %h", cyc, alu_b, m_alu.b);
    end
    if (rsp0_valid !== ev[0]) begin
      n_err++; $display("FAIL rsp0_valid cyc=%0d: got %b want %b", cyc, rsp0_valid, ev[0]);
    end
    if (rsp1_valid !== ev[1]) begin
      n_err++; $display("FAIL rsp1_valid cyc=%0d: got %b want %b", cyc, rsp1_valid, ev[1]);
    end
    if (rsp0_data !== m_rsp[0]) begin
      n_err++; $display("FAIL rsp0_data cyc=%0d: got %h want %h", cyc, rsp0_data, m_rsp[0]);
    end
    if (rsp1_data !== m_rsp[1]) begin
      n_err++; $display("FAIL rsp1_data cyc=%0d: got %h want %h", cyc, rsp1_data, m_rsp[1]);
    end
    if (busy !== eb) begin
      n_err++; $display("FAIL busy cyc=%0d: got %b want %b", cyc, busy, eb);
    end
  endtask

  // Run until every queued op has been issued and answered, within a bound.
  task automatic drain(input int max_cycles);
    int n = 0;
    while ((pend_v[0] || pend_v[1] || q0.size() > 0 || q1.size() > 0 || sched.size() > 0)
           && n < max_cycles) begin
      cycle(1'b0);
      n++;
    end
    n_vec++;
    if (n >= max_cycles) begin
      n_err++; $display("FAIL drain_timeout: got %0d cycles, limit %0d", n, max_cycles);
    end
  endtask

  task automatic test_reset();
    q0.push_back('{OP_ADD, 8'd1, 8'd2});
    q1.push_back('{OP_ADD, 8'd3, 8'd4});
    cycle(1'b1);
    cycle(1'b1);
    grant_log.delete();
    cycle(1'b0);
    n_vec++;
    if (grant_log.size() != 1 || grant_log[0] != 0) begin
      n_err++; $display("FAIL first_grant: got %0d grants, want one grant to req0", grant_log.size());
    end
    drain(30);
  endtask

  task automatic test_single();
    int p1 = pulses[1];
    q0.push_back('{OP_ADD, 8'd25, 8'd17});
    drain(20);
    n_vec += 2;
    if (rsp0_data !== 8'd42) begin
      n_err++; $display("FAIL single_add: got %0d want 42", rsp0_data);
    end
    if (pulses[1] != p1) begin
      n_err++; $display("FAIL single_rsp1: got %0d pulses want 0", pulses[1] - p1);
    end
  endtask

  task automatic test_alternate();
    int want [6] = '{0, 1, 0, 1, 0, 1};
    cycle(1'b1);
    for (int i = 0; i < 3; i++) begin
      q0.push_back('{OP_SUB, 8'd50, 8'd10});
      q1.push_back('{OP_XOR, 8'hF0, 8'h0F});
    end
    grant_log.delete();
    drain(40);
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (i >= grant_log.size() || grant_log[i] != want[i]) begin
        n_err++; $display("FAIL alt_grant[%0d]: got %0d want %0d", i,
                          (i < grant_log.size()) ? grant_log[i] : -1, want[i]);
      end
    end
    n_vec += 2;
    if (rsp0_data !== 8'd40) begin
      n_err++; $display("FAIL alt_sub: got %h want 28", rsp0_data);
    end
    if (rsp1_data !== 8'hFF) begin
      n_err++; $display("FAIL alt_xor: got %h want ff", rsp1_data);
    end
  endtask

  task automatic test_back_to_back();
    int p1 = pulses[1];
    q1.push_back('{OP_ADD, 8'h10, 8'h20});
    q1.push_back('{OP_SUB, 8'h09, 8'h03});
    q1.push_back('{OP_AND, 8'hAA, 8'hCC});
    q1.push_back('{OP_OR,  8'h33, 8'hC3});
    q1.push_back('{OP_XOR, 8'h5A, 8'hFF});
    q1.push_back('{OP_NOT, 8'hAA, 8'h00});
    q1.push_back('{OP_SHL, 8'd10, 8'h00});
    q1.push_back('{OP_SHR, 8'd16, 8'h00});
    drain(40);
    n_vec += 2;
    if (pulses[1] - p1 != 8) begin
      n_err++; $display("FAIL stream_pulses: got %0d want 8", pulses[1] - p1);
    end
    if (rsp1_data !== 8'd8) begin
      n_err++; $display("FAIL stream_shr: got %0d want 8", rsp1_data);
    end
  endtask

  task automatic test_reset_mid();
    int p0, p1;
    q0.push_back('{OP_ADD, 8'h01, 8'h02});
    q1.push_back('{OP_AND, 8'h0F, 8'h3C});
    cycle(1'b0);
    cycle(1'b0);
    cycle(1'b1);
    p0 = pulses[0]; p1 = pulses[1];
    for (int i = 0; i < L + 3; i++) cycle(1'b0);
    n_vec++;
    if (pulses[0] != p0 || pulses[1] != p1) begin
      n_err++; $display("FAIL reset_discard: got %0d pulses want 0", pulses[0] + pulses[1] - p0 - p1);
    end
    q0.push_back('{OP_OR, 8'h0F, 8'hF0});
    drain(20);
    n_vec++;
    if (rsp0_data !== 8'hFF) begin
      n_err++; $display("FAIL reset_or: got %h want ff", rsp0_data);
    end
  endtask

  task automatic test_held_valid();
    cycle(1'b1);
    q0.push_back('{OP_ADD, 8'h11, 8'h22});
    q1.push_back('{OP_SUB, 8'h5A, 8'hA5});
    cycle(1'b0);
    cycle(1'b0);
    n_vec += 3;
    if (alu_op_code !== OP_SUB) begin
      n_err++; $display("FAIL held_op: got %h want 1", alu_op_code);
    end
    if (alu_a !== 8'h5A) begin
      n_err++; $display("FAIL held_a: got %h want 5a", alu_a);
    end
    if (alu_b !== 8'hA5) begin
      n_err++; $display("FAIL held_b: got %h want a5", alu_b);
    end
    drain(20);
  endtask

  task automatic test_random();
    gap_en = 1;
    for (int i = 0; i < 60; i++) begin
      q0.push_back('{3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)});
      q1.push_back('{3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom)});
    end
    drain(1000);
    gap_en = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_back_to_back();
    test_reset_mid();
    test_held_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
